button_bounce_emulator: RTL and testbench

BUTTON_BOUNCE_EMULATOR -- requirements
Module: button_bounce_emulator

---
 rtl/button_bounce_emulator_pkg.sv | 18 +
 rtl/button_bounce_emulator_lfsr8.sv | 24 ++
 rtl/button_bounce_emulator.sv | 157 +++++++++++++++
 tb/tb_button_bounce_emulator.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_bounce_emulator_pkg.sv
// Shared types and constants for the pushbutton bounce emulator.
// Holds the FSM state type, LFSR seed/taps and the jitter width.
package button_bounce_emulator_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_BOUNCE_PRESS,
        ST_HELD,
        ST_BOUNCE_RELEASE
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 : feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int JIT_W = 3;

endpackage

// File: rtl/button_bounce_emulator_lfsr8.sv
// 8-bit Fibonacci LFSR used as the jitter source.
// Ports: clk_ms, rst_n (async, active-low), en (advance), q (state).
module lfsr8
    import button_bounce_emulator_pkg::*;
(
    input  logic       clk_ms,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge clk_ms or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= LFSR_SEED;
        end else if (en) begin
            r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/button_bounce_emulator.sv
// Emulates a bouncing pushbutton: on press/release requests the output
// toggles 2*bounce_num times, spaced by tick-counted gaps, then settles.
// Ports: clk_ms, rst_n, tick, press_req, release_req, bounce_num,
//        bounce_gap, jitter_en -> btn_out, busy, done.
module button_bounce_emulator
    import button_bounce_emulator_pkg::*;
#(
    parameter int GAP_W = 8,
    parameter int NB_W  = 4
) (
    input  logic             clk_ms,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             press_req,
    input  logic             release_req,
    input  logic [NB_W-1:0]  bounce_num,
    input  logic [GAP_W-1:0] bounce_gap,
    input  logic             jitter_en,
    output logic             btn_out,
    output logic             busy,
    output logic             done
);

    localparam int IV_W = GAP_W + 1;
    localparam int TC_W = NB_W + 1;

    state_t            r_state;
    logic              r_btn;
    logic              r_done;
    logic [IV_W-1:0]   r_gap_cnt;
    logic [IV_W-1:0]   r_interval;
    logic [TC_W-1:0]   r_tog_cnt;
    logic [NB_W-1:0]   r_num;
    logic [GAP_W-1:0]  r_gap;
    logic              r_jit;

    state_t            w_state_nxt;
    logic              w_btn_nxt;
    logic              w_done_nxt;
    logic [IV_W-1:0]   w_gap_cnt_nxt;
    logic [IV_W-1:0]   w_interval_nxt;
    logic [TC_W-1:0]   w_tog_cnt_nxt;
    logic [NB_W-1:0]   w_num_nxt;
    logic [GAP_W-1:0]  w_gap_nxt;
    logic              w_jit_nxt;

    logic [7:0]        w_lfsr;
    logic [JIT_W-1:0]  w_jitter;
    logic              w_unused_lfsr;
    logic              w_hit;
    logic              w_last;

    lfsr8 u_lfsr (
        .clk_ms (clk_ms),
        .rst_n  (rst_n),
        .en     (tick),
        .q      (w_lfsr)
    );

    assign w_jitter      = w_lfsr[JIT_W-1:0];
    assign w_unused_lfsr = ^w_lfsr[7:JIT_W];

    // Gap of 0 would never expire, so it is stretched to one tick.
    function automatic logic [IV_W-1:0] calc_iv(
        input logic [GAP_W-1:0] g,
        input logic             j,
        input logic [JIT_W-1:0] l
    );
        logic [IV_W-1:0] base;
        base = (g == '0) ? IV_W'(1) : IV_W'(g);
        return base + (j ? IV_W'(l) : '0);
    endfunction

    assign w_hit  = tick && ((r_gap_cnt + IV_W'(1)) == r_interval);
    assign w_last = (r_tog_cnt + TC_W'(1)) == {r_num, 1'b0};

    always_ff @(posedge clk_ms or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RELEASED;
            r_btn      <= 1'b0;
            r_done     <= 1'b0;
            r_gap_cnt  <= '0;
            r_interval <= '0;
            r_tog_cnt  <= '0;
            r_num      <= '0;
            r_gap      <= '0;
            r_jit      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_btn      <= w_btn_nxt;
            r_done     <= w_done_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_interval <= w_interval_nxt;
            r_tog_cnt  <= w_tog_cnt_nxt;
            r_num      <= w_num_nxt;
            r_gap      <= w_gap_nxt;
            r_jit      <= w_jit_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_btn_nxt      = r_btn;
        w_done_nxt     = 1'b0;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_interval_nxt = r_interval;
        w_tog_cnt_nxt  = r_tog_cnt;
        w_num_nxt      = r_num;
        w_gap_nxt      = r_gap;
        w_jit_nxt      = r_jit;

        unique case (r_state)
            ST_RELEASED, ST_HELD: begin
                if ((r_state == ST_RELEASED && press_req) ||
                    (r_state == ST_HELD && release_req)) begin
                    w_btn_nxt      = (r_state == ST_RELEASED);
                    w_num_nxt      = bounce_num;
                    w_gap_nxt      = bounce_gap;
                    w_jit_nxt      = jitter_en;
                    w_gap_cnt_nxt  = '0;
                    w_tog_cnt_nxt  = '0;
                    w_interval_nxt = calc_iv(bounce_gap, jitter_en,
                                             w_jitter);
                    if (bounce_num == '0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = (r_state == ST_RELEASED) ?
                                      ST_HELD : ST_RELEASED;
                    end else begin
                        w_state_nxt = (r_state == ST_RELEASED) ?
                                      ST_BOUNCE_PRESS : ST_BOUNCE_RELEASE;
                    end
                end
            end
            ST_BOUNCE_PRESS, ST_BOUNCE_RELEASE: begin
                if (w_hit) begin
                    w_btn_nxt      = ~r_btn;
                    w_gap_cnt_nxt  = '0;
                    w_tog_cnt_nxt  = r_tog_cnt + TC_W'(1);
                    w_interval_nxt = calc_iv(r_gap, r_jit, w_jitter);
                    if (w_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = (r_state == ST_BOUNCE_PRESS) ?
                                      ST_HELD : ST_RELEASED;
                    end
                end else if (tick) begin
                    w_gap_cnt_nxt = r_gap_cnt + IV_W'(1);
                end
            end
        endcase
    end

    assign btn_out = r_btn;
    assign done    = r_done;
    assign busy    = (r_state == ST_BOUNCE_PRESS) ||
                     (r_state == ST_BOUNCE_RELEASE);

endmodule

// File: tb/tb_button_bounce_emulator.sv
// Randomised and directed bench for button_bounce_emulator.
// A countdown-based behavioural model is compared every cycle.
module tb_button_bounce_emulator;

    logic       clk_ms = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       press_req = 1'b0;
    logic       release_req = 1'b0;
    logic [3:0] bounce_num = '0;
    logic [7:0] bounce_gap = '0;
    logic       jitter_en = 1'b0;
    logic       btn_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk_ms = ~clk_ms;

    button_bounce_emulator #(.GAP_W(8), .NB_W(4)) dut (
        .clk_ms      (clk_ms),
        .rst_n       (rst_n),
        .tick        (tick),
        .press_req   (press_req),
        .release_req (release_req),
        .bounce_num  (bounce_num),
        .bounce_gap  (bounce_gap),
        .jitter_en   (jitter_en),
        .btn_out     (btn_out),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 up, 1 pressing, 2 down, 3 releasing.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int gap_of(input int g, input bit j,
                                  input logic [7:0] s);
        int jit;
        jit = j ? int'(s[2:0]) : 0;
        return ((g == 0) ? 1 : g) + jit;
    endfunction

    int         m_ph = 0;
    bit         m_btn = 0;
    bit         m_done = 0;
    int         m_left = 0;
    int         m_togs = 0;
    int         m_gap = 0;
    bit         m_jit = 0;
    logic [7:0] m_lfsr = 8'hA5;
    int         m_ivq[$];

    always @(posedge clk_ms or negedge rst_n) begin : mdl
        logic [7:0] cur;
        if (!rst_n) begin
            m_ph = 0; m_btn = 0; m_done = 0;
            m_left = 0; m_togs = 0; m_lfsr = 8'hA5;
        end else begin
            cur = m_lfsr;
            if (tick) m_lfsr = lfsr_step(m_lfsr);
            m_done = 0;
            if ((m_ph == 0 && press_req) || (m_ph == 2 && release_req)) begin
                m_btn = (m_ph == 0);
                m_gap = int'(bounce_gap);
                m_jit = jitter_en;
                if (bounce_num == 0) begin
                    m_ph = (m_ph == 0) ? 2 : 0;
                    m_done = 1;
                end else begin
                    m_togs = 2 * int'(bounce_num);
                    m_left = gap_of(m_gap, m_jit, cur);
                    m_ivq.push_back(m_left);
                    m_ph = m_ph + 1;
                end
            end else if ((m_ph == 1 || m_ph == 3) && tick) begin
                m_left--;
                if (m_left == 0) begin
                    m_btn = !m_btn;
                    m_togs--;
                    if (m_togs == 0) begin
                        m_ph = (m_ph + 1) % 4;
                        m_done = 1;
                    end else begin
                        m_left = gap_of(m_gap, m_jit, cur);
                        m_ivq.push_back(m_left);
                    end
                end
            end
        end
    end

    // Per-cycle comparison plus an edge/gap monitor.
    int   mon_ticks = 0;
    int   mon_togs = 0;
    int   mon_dones = 0;
    bit   mon_busy_seen = 0;
    logic mon_prev = 1'b0;
    int   mon_gaps[$];

    initial forever begin
        @(posedge clk_ms);
        #3;
        chk("btn_out", int'(btn_out), int'(m_btn));
        chk("busy", int'(busy), int'(m_ph == 1 || m_ph == 3));
        chk("done", int'(done), int'(m_done));
        if (tick) mon_ticks++;
        if (btn_out !== mon_prev) begin
            mon_gaps.push_back(mon_ticks);
            mon_ticks = 0;
            mon_togs++;
        end
        mon_prev = btn_out;
        if (done) mon_dones++;
        if (busy) mon_busy_seen = 1;
    end

    int tp = 4;
    bit trand = 0;
    int tcnt = 0;

    task automatic cyc(input bit p = 0, input bit r = 0);
        @(negedge clk_ms);
        tcnt++;
        tick = trand ? ($urandom_range(0, 2) == 0) : (tcnt % tp == 0);
        press_req = p;
        release_req = r;
    endtask

    task automatic mon_clr();
        mon_togs = 0;
        mon_dones = 0;
        mon_ticks = 0;
        mon_busy_seen = 0;
        mon_gaps.delete();
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        cyc();
        cyc();
        while (busy && n < maxc) begin
            cyc();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", maxc);
        end
    endtask

    task automatic chk_gaps(input int n, input int v);
        chk("gap_count", mon_gaps.size(), n + 1);
        for (int k = 1; k <= n; k++)
            if (k < mon_gaps.size()) chk("gap_len", mon_gaps[k], v);
    endtask

    initial begin
        chk("lfsr_model1", int'(lfsr_step(8'hA5)), 8'h4A);
        chk("lfsr_model2", int'(lfsr_step(8'h4A)), 8'h95);
        chk("lfsr_model3", int'(lfsr_step(8'h95)), 8'h2A);

        repeat (3) @(negedge clk_ms);
        chk("rst_btn", int'(btn_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;

        // Three bounce pairs, gap 2, tick every 4 clocks
        bounce_num = 4'd3; bounce_gap = 8'd2; jitter_en = 0; tp = 4;
        mon_clr();
        cyc(1, 0);
        wait_idle(500);
        chk("p030_edges", mon_togs, 7);
        chk_gaps(6, 2);
        chk("p030_dones", mon_dones, 1);
        chk("p030_btn", int'(btn_out), 1);
        chk("p030_busy", int'(busy), 0);

        // Zero bounces: immediate edges with done
        bounce_num = 4'd0;
        mon_clr();
        cyc(0, 1);
        cyc();
        chk("p031_rel_btn", int'(btn_out), 0);
        chk("p031_rel_done", int'(done), 1);
        cyc();
        chk("p031_done_pulse", int'(done), 0);
        cyc(1, 0);
        cyc();
        chk("p031_prs_btn", int'(btn_out), 1);
        chk("p031_prs_done", int'(done), 1);
        cyc(0, 1);
        cyc();
        chk("p031_rel2_btn", int'(btn_out), 0);
        cyc();
        chk("p031_busy_seen", int'(mon_busy_seen), 0);
        chk("p031_dones", mon_dones, 3);

        // Mismatched requests are ignored
        mon_clr();
        repeat (5) cyc(0, 1);
        cyc();
        chk("p032_rel_idle", mon_togs, 0);
        bounce_num = 4'd2; bounce_gap = 8'd3; tp = 2;
        mon_clr();
        cyc(1, 0);
        cyc();
        repeat (6) cyc(1, 1);
        wait_idle(500);
        chk("p032_edges", mon_togs, 5);
        chk_gaps(4, 3);
        chk("p032_dones", mon_dones, 1);
        bounce_num = 4'd0;
        cyc(0, 1);
        cyc();

        // Reset in mid-bounce
        bounce_num = 4'd2; bounce_gap = 8'd2; tp = 3;
        mon_clr();
        cyc(1, 0);
        for (int n = 0; n < 300 && mon_togs < 4; n++) cyc();
        chk("p033_reach3", mon_togs, 4);
        rst_n = 1'b0;
        #1;
        chk("p033_rst_btn", int'(btn_out), 0);
        chk("p033_rst_busy", int'(busy), 0);
        chk("p033_rst_done", int'(done), 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk("p033_no_done", mon_dones, 0);
        bounce_gap = 8'd1;
        mon_clr();
        cyc(1, 0);
        wait_idle(500);
        chk("p033_edges", mon_togs, 5);
        chk_gaps(4, 1);
        chk("p033_dones", mon_dones, 1);
        chk("p033_btn", int'(btn_out), 1);

        // Inputs changed mid-sequence have no effect
        bounce_num = 4'd2; bounce_gap = 8'd2;
        mon_clr();
        cyc(0, 1);
        cyc();
        bounce_num = 4'd7; bounce_gap = 8'd5; jitter_en = 1;
        wait_idle(500);
        chk("p035_edges", mon_togs, 5);
        chk_gaps(4, 2);
        chk("p035_btn", int'(btn_out), 0);

        // Jittered gaps against the reference LFSR
        trand = 1; jitter_en = 1; bounce_gap = 8'd0; bounce_num = 4'd4;
        mon_clr();
        m_ivq.delete();
        cyc(1, 0);
        wait_idle(3000);
        chk("p034_edges", mon_togs, 9);
        chk("p034_ivq", m_ivq.size(), 8);
        for (int k = 1; k <= 8; k++) begin
            if (k < mon_gaps.size() && k <= m_ivq.size()) begin
                chk("p034_range", int'(mon_gaps[k] >= 1 && mon_gaps[k] <= 8), 1);
                chk("p034_gap", mon_gaps[k], m_ivq[k-1]);
            end
        end

        // Random traffic, the per-cycle compare does the checking
        for (int i = 0; i < 1500; i++) begin
            bounce_num = 4'($urandom_range(0, 3));
            bounce_gap = 8'($urandom_range(0, 3));
            jitter_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
